gate_table_arbiter: RTL and testbench
=====================================

# gate_table_arbiter

Shares one gate matrix table between several requesters, such as the per-qubit state update engines. Requests are arbitrated round-robin. The arbiter drives the table's 5-bit gate code and one-cycle load strobe, then waits for the table's completion pulse and acknowledges the winner. A one-entry cache of the last loaded gate lets a repeat request for the same gate skip the table reload. The table's full 2x2 complex matrix result (its 2x2x2 `result` array) is wired straight to all requesters. The arbiter does not carry matrix data.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- TIMEOUT, 64: WAIT cycles allowed before a load is abandoned, 2..255
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- req_valid  in  NUM_REQ  bit i means requester i wants a matrix; held until its ack
- req_gate  in  5*NUM_REQ  gate code of requester i at [5i+4:5i]; stable while req_valid[i]=1
- req_ack  out  NUM_REQ  one-hot one-cycle pulse; matrix for the owner's gate is valid on the table result
- tbl_gate  out  5  gate code to the table; held from ISSUE through WAIT
- tbl_ready  out  1  one-cycle load strobe to the table
- tbl_done_pulse  in  1  table completion pulse
- owner  out  max(1,$clog2(NUM_REQ))  index of the current or last grantee
- busy  out  1  1 in any state other than IDLE
- timeout_err  out  1  sticky; set on load timeout, cleared only by reset

## Operation
- All outputs are registered. Reset values: req_ack=0, tbl_gate=0, tbl_ready=0, owner=0, busy=0, timeout_err=0.
- Internal reset values: state=IDLE, rr_ptr=0, cache_valid=0, cache_gate=0, wait_cnt=0.
- The table's own reset input is tied to ~reset at top level.

State machine:
- IDLE
  - If any req_valid bit is set, grant the first set bit scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Latch owner=i and gate=req_gate[i]. Set rr_ptr=(i+1) mod NUM_REQ.
  - If cache_valid and cache_gate==gate, go to ACK. Otherwise go to ISSUE.
- ISSUE
  - tbl_ready=1 for exactly this cycle; tbl_gate=latched gate.
  - cache_valid<=0, wait_cnt<=0, then go to WAIT.
- WAIT
  - On tbl_done_pulse: cache_gate<=gate, cache_valid<=1, go to ACK.
  - Otherwise wait_cnt increments. If wait_cnt==TIMEOUT-1 and no pulse: timeout_err<=1, cache_valid stays 0, go to IDLE with no ack. The request stays pending and is re-arbitrated.
- ACK
  - req_ack[owner]=1 for exactly this cycle, then go to IDLE.

Requester and ack rules:
- The requester deasserts req_valid on the edge that ends its ack cycle.
- If req_valid is still high in the next IDLE, it is treated as a new request.
- The matrix on the table result is valid from the ack cycle until the next tbl_ready pulse. A requester must copy it or finish using it before then.

Boundary conditions:
- tbl_done_pulse outside WAIT is ignored (stale pulse after reset or timeout).
- A done pulse in the same cycle the timeout would fire counts as success.
- A req_valid deasserted by a non-owner has no effect. The owner must not drop req_valid before its ack; behaviour if it does is undefined (protocol violation).
- Reset asserted mid-WAIT: outputs zero at once, cache invalid. The next request always reloads.

## Timing
- Cycle 0: IDLE samples a request.
- Hit: ACK in cycle 1. One request per 2 cycles sustained.
- Miss: ISSUE (tbl_ready) in cycle 1, WAIT from cycle 2. If tbl_done_pulse arrives k cycles after tbl_ready, the ack is in the cycle after the pulse, i.e. cycle k+2.
- There is no back-to-back grant. At least one IDLE cycle separates successive grants.
- Timeout: WAIT lasts exactly TIMEOUT cycles, then IDLE.

## Test plan
- **Reset.** Drive reset=0 with random inputs toggling -> all outputs 0 throughout. After release, no tbl_ready and no ack with req_valid=0.
- **Single miss.** Table model pulses done 10 cycles after ready; req_valid[2]=1, req_gate[2]=5'd3 -> tbl_gate=3, one tbl_ready in cycle 1, owner=2, req_ack=4'b0100 in cycle 12 only, busy high in cycles 1-12.
- **Cache hit.** Then req_valid[1]=1 with gate 3 -> no tbl_ready, req_ack=4'b0010 one cycle after the grant. Then gate 5'd7 -> reload, after which cache_gate=7.
- **Round-robin.** After a last grant to 2, all four requesters hold distinct gates (1, 2, 4, 5) -> grant order 3, 0, 1, 2, each with its own tbl_ready. Each ack is one-hot to the matching requester.
- **Timeout.** Table never pulses, only requester 0 active -> timeout_err rises after 64 WAIT cycles with no ack, then a second tbl_ready. A pulse then arriving on time gives req_ack[0] and timeout_err stays 1.
- **Reset mid-load.** Assert reset in WAIT cycle 5 -> outputs clear asynchronously. After release, a stale tbl_done_pulse is ignored (no ack). A new request for the same gate produces a fresh tbl_ready.

Source files
------------

// File: rtl/gate_table_arbiter.sv
// Round-robin arbiter sharing one gate matrix table among requesters.
// A one-entry cache of the last loaded gate lets repeat requests skip the reload.
module gate_table_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [5*NUM_REQ-1:0]       req_gate,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic [4:0]                 tbl_gate,
    output logic                       tbl_ready,
    input  logic                       tbl_done_pulse,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int IW = OW + 1;
    localparam int CW = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t            r_state;
    logic [OW-1:0]     r_rr_ptr;
    logic              r_cache_valid;
    logic [4:0]        r_cache_gate;
    logic [CW-1:0]     r_wait_cnt;
    logic [4:0]        r_tbl_gate;
    logic [OW-1:0]     r_owner;
    logic [NUM_REQ-1:0] r_ack;
    logic              r_tbl_ready;
    logic              r_busy;
    logic              r_timeout_err;

    state_t            w_state_nx;
    logic [OW-1:0]     w_rr_nx;
    logic              w_cv_nx;
    logic [4:0]        w_cg_nx;
    logic [CW-1:0]     w_cnt_nx;
    logic [4:0]        w_gate_nx;
    logic [OW-1:0]     w_owner_nx;
    logic [NUM_REQ-1:0] w_ack_nx;
    logic              w_rdy_nx;
    logic              w_terr_nx;

    logic              w_found;
    logic [OW-1:0]     w_pick;
    logic [IW-1:0]     w_idx;
    logic [4:0]        w_pick_gate;

    // Scan from the round-robin pointer, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + IW'(k);
            if (w_idx >= IW'(NUM_REQ)) begin
                w_idx = w_idx - IW'(NUM_REQ);
            end
            if (!w_found && req_valid[w_idx[OW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[OW-1:0];
            end
        end
    end

    assign w_pick_gate = req_gate[5*int'(w_pick) +: 5];

    always_comb begin
        w_state_nx = r_state;
        w_rr_nx    = r_rr_ptr;
        w_cv_nx    = r_cache_valid;
        w_cg_nx    = r_cache_gate;
        w_cnt_nx   = r_wait_cnt;
        w_gate_nx  = r_tbl_gate;
        w_owner_nx = r_owner;
        w_ack_nx   = '0;
        w_rdy_nx   = 1'b0;
        w_terr_nx  = r_timeout_err;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_owner_nx = w_pick;
                    w_gate_nx  = w_pick_gate;
                    w_rr_nx    = (w_pick == OW'(NUM_REQ - 1)) ? '0 : w_pick + 1'b1;
                    if (r_cache_valid && r_cache_gate == w_pick_gate) begin
                        w_state_nx       = S_ACK;
                        w_ack_nx[w_pick] = 1'b1;
                    end else begin
                        w_state_nx = S_ISSUE;
                        w_rdy_nx   = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                w_cv_nx    = 1'b0;
                w_cnt_nx   = '0;
                w_state_nx = S_WAIT;
            end
            S_WAIT: begin
                // A pulse on the final wait cycle still wins over the timeout.
                if (tbl_done_pulse) begin
                    w_cg_nx           = r_tbl_gate;
                    w_cv_nx           = 1'b1;
                    w_state_nx        = S_ACK;
                    w_ack_nx[r_owner] = 1'b1;
                end else if (r_wait_cnt == CW'(TIMEOUT - 1)) begin
                    w_terr_nx  = 1'b1;
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx = r_wait_cnt + 1'b1;
                end
            end
            S_ACK: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_cache_valid <= 1'b0;
            r_cache_gate  <= '0;
            r_wait_cnt    <= '0;
            r_tbl_gate    <= '0;
            r_owner       <= '0;
            r_ack         <= '0;
            r_tbl_ready   <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_rr_ptr      <= w_rr_nx;
            r_cache_valid <= w_cv_nx;
            r_cache_gate  <= w_cg_nx;
            r_wait_cnt    <= w_cnt_nx;
            r_tbl_gate    <= w_gate_nx;
            r_owner       <= w_owner_nx;
            r_ack         <= w_ack_nx;
            r_tbl_ready   <= w_rdy_nx;
            r_busy        <= (w_state_nx != S_IDLE);
            r_timeout_err <= w_terr_nx;
        end
    end

    assign req_ack     = r_ack;
    assign tbl_gate    = r_tbl_gate;
    assign tbl_ready   = r_tbl_ready;
    assign owner       = r_owner;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_gate_table_arbiter.sv
// Scenario bench for gate_table_arbiter plus a randomized run checked
// against a transaction-level schedule model.
module tb_gate_table_arbiter;

    localparam int N  = 4;
    localparam int TO = 64;
    localparam int GW = 5 * N;

    logic          clk;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [GW-1:0] req_gate;
    logic [N-1:0]  req_ack;
    logic [4:0]    tbl_gate;
    logic          tbl_ready;
    logic          tbl_done_pulse;
    logic [1:0]    owner;
    logic          busy;
    logic          timeout_err;

    int total;
    int bad;

    wire [13:0] w_outs = {req_ack, tbl_gate, tbl_ready, owner, busy, timeout_err};

    gate_table_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_gate       (req_gate),
        .req_ack        (req_ack),
        .tbl_gate       (tbl_gate),
        .tbl_ready      (tbl_ready),
        .tbl_done_pulse (tbl_done_pulse),
        .owner          (owner),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_gate(input int r, input logic [4:0] g);
        req_gate[5*r +: 5] = g;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req_valid = '0;
        tbl_done_pulse = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            req_valid = N'($urandom);
            req_gate = GW'($urandom);
            tbl_done_pulse = 1'($urandom);
            #3;
            total++;
            if (w_outs !== '0) begin
                bad++;
                $display("FAIL reset_outs: got %h want 0", w_outs);
            end
            step();
        end
        req_valid = '0;
        tbl_done_pulse = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if ({tbl_ready, req_ack, busy} !== 6'b0) begin
                bad++;
                $display("FAIL reset_idle: rdy=%b ack=%b busy=%b want 0", tbl_ready, req_ack, busy);
            end
        end
    endtask

    task automatic test_single_miss();
        set_gate(2, 5'd3);
        req_valid = 4'b0100;
        for (int c = 1; c <= 14; c++) begin
            step();
            total++;
            if (tbl_ready !== (c == 1)) begin
                bad++;
                $display("FAIL miss_ready c=%0d: got %b", c, tbl_ready);
            end
            total++;
            if (req_ack !== ((c == 12) ? 4'b0100 : 4'b0000)) begin
                bad++;
                $display("FAIL miss_ack c=%0d: got %b", c, req_ack);
            end
            total++;
            if (busy !== (c >= 1 && c <= 12)) begin
                bad++;
                $display("FAIL miss_busy c=%0d: got %b", c, busy);
            end
            if (c == 1) begin
                total++;
                if (tbl_gate !== 5'd3 || owner !== 2'd2) begin
                    bad++;
                    $display("FAIL miss_gate: gate=%0d owner=%0d want 3/2", tbl_gate, owner);
                end
            end
            tbl_done_pulse = (c == 11);
            if (c == 13) req_valid[2] = 1'b0;
        end
    endtask

    task automatic test_cache_hit();
        set_gate(1, 5'd3);
        req_valid = 4'b0010;
        for (int c = 1; c <= 3; c++) begin
            step();
            total++;
            if (tbl_ready !== 1'b0 || req_ack !== ((c == 1) ? 4'b0010 : 4'b0000)) begin
                bad++;
                $display("FAIL hit3 c=%0d: rdy=%b ack=%b", c, tbl_ready, req_ack);
            end
            if (c == 1) begin
                total++;
                if (owner !== 2'd1) begin
                    bad++;
                    $display("FAIL hit3_owner: got %0d want 1", owner);
                end
            end
            if (c == 2) req_valid[1] = 1'b0;
        end
        set_gate(1, 5'd7);
        req_valid = 4'b0010;
        for (int c = 1; c <= 6; c++) begin
            step();
            total++;
            if (tbl_ready !== (c == 1) || req_ack !== ((c == 5) ? 4'b0010 : 4'b0000)) begin
                bad++;
                $display("FAIL reload7 c=%0d: rdy=%b ack=%b", c, tbl_ready, req_ack);
            end
            if (c == 1) begin
                total++;
                if (tbl_gate !== 5'd7) begin
                    bad++;
                    $display("FAIL reload7_gate: got %0d want 7", tbl_gate);
                end
            end
            tbl_done_pulse = (c == 4);
            if (c == 6) req_valid[1] = 1'b0;
        end
        req_valid = 4'b0010;
        for (int c = 1; c <= 3; c++) begin
            step();
            total++;
            if (tbl_ready !== 1'b0 || req_ack !== ((c == 1) ? 4'b0010 : 4'b0000)) begin
                bad++;
                $display("FAIL hit7 c=%0d: rdy=%b ack=%b", c, tbl_ready, req_ack);
            end
            if (c == 2) req_valid[1] = 1'b0;
        end
    endtask

    task automatic test_round_robin();
        int order[4];
        logic [4:0] gts[4];
        int n;
        order = '{3, 0, 1, 2};
        gts = '{5'd1, 5'd2, 5'd4, 5'd5};
        set_gate(2, 5'd7);
        req_valid = 4'b0100;
        for (int c = 1; c <= 3; c++) begin
            step();
            total++;
            if (tbl_ready !== 1'b0 || req_ack !== ((c == 1) ? 4'b0100 : 4'b0000)) begin
                bad++;
                $display("FAIL rr_pre c=%0d: rdy=%b ack=%b", c, tbl_ready, req_ack);
            end
            if (c == 2) req_valid[2] = 1'b0;
        end
        for (int i = 0; i < N; i++) set_gate(i, gts[i]);
        req_valid = 4'b1111;
        for (int c = 1; c <= 22; c++) begin
            step();
            n = c / 5;
            total++;
            if (tbl_ready !== (c % 5 == 1 && c < 20)) begin
                bad++;
                $display("FAIL rr_ready c=%0d: got %b", c, tbl_ready);
            end
            total++;
            if (req_ack !== ((c % 5 == 4 && c < 20) ? (4'b0001 << order[n]) : 4'b0000)) begin
                bad++;
                $display("FAIL rr_ack c=%0d: got %b", c, req_ack);
            end
            total++;
            if (busy !== (c < 20 && c % 5 != 0)) begin
                bad++;
                $display("FAIL rr_busy c=%0d: got %b", c, busy);
            end
            if (c % 5 == 1 && c < 20) begin
                total++;
                if (owner !== 2'(order[n]) || tbl_gate !== gts[order[n]]) begin
                    bad++;
                    $display("FAIL rr_grant c=%0d: owner=%0d gate=%0d want %0d/%0d",
                             c, owner, tbl_gate, order[n], gts[order[n]]);
                end
            end
            tbl_done_pulse = (c % 5 == 3 && c < 20);
            if (c % 5 == 0 && c >= 5 && c <= 20) req_valid[order[c/5-1]] = 1'b0;
        end
    endtask

    task automatic test_timeout();
        set_gate(0, 5'd9);
        req_valid = 4'b0001;
        for (int c = 1; c <= 134; c++) begin
            step();
            total++;
            if (tbl_ready !== (c == 1 || c == 67)) begin
                bad++;
                $display("FAIL to_ready c=%0d: got %b", c, tbl_ready);
            end
            total++;
            if (req_ack !== ((c == 132) ? 4'b0001 : 4'b0000)) begin
                bad++;
                $display("FAIL to_ack c=%0d: got %b", c, req_ack);
            end
            total++;
            if (timeout_err !== (c >= 66)) begin
                bad++;
                $display("FAIL to_err c=%0d: got %b", c, timeout_err);
            end
            total++;
            if (busy !== !(c == 66 || c >= 133)) begin
                bad++;
                $display("FAIL to_busy c=%0d: got %b", c, busy);
            end
            tbl_done_pulse = (c == 131);
            if (c == 133) req_valid[0] = 1'b0;
        end
    endtask

    task automatic test_reset_mid_load();
        set_gate(1, 5'd11);
        req_valid = 4'b0010;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == 1) begin
                total++;
                if (tbl_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL rml_ready: got %b want 1", tbl_ready);
                end
            end
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (w_outs !== '0) begin
            bad++;
            $display("FAIL rml_async: got %h want 0", w_outs);
        end
        req_valid = '0;
        repeat (2) step();
        reset = 1'b1;
        step();
        tbl_done_pulse = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            tbl_done_pulse = 1'b0;
            total++;
            if ({req_ack, tbl_ready, busy} !== 6'b0) begin
                bad++;
                $display("FAIL rml_stale c=%0d: ack=%b rdy=%b busy=%b", c, req_ack, tbl_ready, busy);
            end
        end
        req_valid = 4'b0010;
        for (int c = 1; c <= 5; c++) begin
            step();
            total++;
            if (tbl_ready !== (c == 1) || req_ack !== ((c == 4) ? 4'b0010 : 4'b0000)) begin
                bad++;
                $display("FAIL rml_reload c=%0d: rdy=%b ack=%b", c, tbl_ready, req_ack);
            end
            tbl_done_pulse = (c == 3);
            if (c == 5) req_valid[1] = 1'b0;
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        set_gate(3, 5'd11);
        req_valid = 4'b1010;
        for (int c = 1; c <= 7; c++) begin
            step();
            total++;
            if (tbl_ready !== (c == 1)) begin
                bad++;
                $display("FAIL rst_cache_ready c=%0d: got %b", c, tbl_ready);
            end
            total++;
            if (req_ack !== ((c == 3) ? 4'b0010 : (c == 5) ? 4'b1000 : 4'b0000)) begin
                bad++;
                $display("FAIL rst_rr_ack c=%0d: got %b", c, req_ack);
            end
            total++;
            if (busy !== ((c >= 1 && c <= 3) || c == 5)) begin
                bad++;
                $display("FAIL rst_busy c=%0d: got %b", c, busy);
            end
            tbl_done_pulse = (c == 2);
            if (c == 4) req_valid[1] = 1'b0;
            if (c == 6) req_valid[3] = 1'b0;
        end
    endtask

    task automatic test_random();
        int idle_at, exp_rdy, exp_ack, pulse_at, grant_cyc, mrr, gwin, w, k;
        bit found, cv;
        logic [4:0] cg, g, exp_g;
        logic [N-1:0] exp_vec;
        do_reset();
        mrr = 0; cv = 1'b0; cg = '0; exp_g = '0;
        idle_at = 0; exp_rdy = -5; exp_ack = -5; pulse_at = -5; grant_cyc = -5;
        exp_vec = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (cyc > 0) begin
                step();
                total++;
                if (tbl_ready !== (cyc == exp_rdy)) begin
                    bad++;
                    $display("FAIL rnd_ready cyc=%0d: got %b want %b", cyc, tbl_ready, cyc == exp_rdy);
                end
                if (cyc == exp_rdy) begin
                    total++;
                    if (tbl_gate !== exp_g) begin
                        bad++;
                        $display("FAIL rnd_gate cyc=%0d: got %0d want %0d", cyc, tbl_gate, exp_g);
                    end
                end
                total++;
                if (req_ack !== ((cyc == exp_ack) ? exp_vec : 4'b0000)) begin
                    bad++;
                    $display("FAIL rnd_ack cyc=%0d: got %b want %b", cyc, req_ack,
                             (cyc == exp_ack) ? exp_vec : 4'b0000);
                end
                total++;
                if (busy !== (cyc > grant_cyc && cyc < idle_at)) begin
                    bad++;
                    $display("FAIL rnd_busy cyc=%0d: got %b", cyc, busy);
                end
            end
            tbl_done_pulse = (cyc == pulse_at);
            if (cyc == exp_ack + 1) req_valid = req_valid & ~exp_vec;
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && !(cyc == exp_ack + 1 && exp_vec[i])
                    && $urandom_range(0, 3) == 0) begin
                    set_gate(i, 5'($urandom_range(0, 3)));
                    req_valid[i] = 1'b1;
                end
            end
            if (cyc >= idle_at && req_valid != '0) begin
                found = 1'b0;
                gwin = 0;
                for (int j = 0; j < N; j++) begin
                    w = (mrr + j) % N;
                    if (!found && req_valid[w]) begin
                        found = 1'b1;
                        gwin = w;
                    end
                end
                g = req_gate[5*gwin +: 5];
                mrr = (gwin + 1) % N;
                exp_vec = '0;
                exp_vec[gwin] = 1'b1;
                grant_cyc = cyc;
                if (cv && cg == g) begin
                    exp_ack = cyc + 1;
                    idle_at = cyc + 2;
                end else begin
                    k = $urandom_range(1, 8);
                    exp_rdy = cyc + 1;
                    exp_g = g;
                    pulse_at = cyc + 1 + k;
                    exp_ack = cyc + k + 2;
                    idle_at = cyc + k + 3;
                    cv = 1'b1;
                    cg = g;
                end
            end
        end
        req_valid = '0;
        tbl_done_pulse = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b0;
        req_valid = '0;
        req_gate = '0;
        tbl_done_pulse = 1'b0;
        test_reset();
        test_single_miss();
        test_cache_hit();
        test_round_robin();
        test_timeout();
        test_reset_mid_load();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
